register_mips_param: RTL and testbench
======================================

# register_mips_param

Parametrised MIPS-style register file with byte-lane write enables, configurable depth and width, optional hardwired-zero register 0 and optional write-to-read bypass. It also has a free-running scan port for stepping through register contents on board LEDs. It succeeds the fixed 4x4 board register file and sits between the switch/button front end (debounced step pulses) and the datapath or LED display.

## Interface
- `DATA_W`, 32, register width in bits; must be a multiple of `LANE_W`
- `LANE_W`, 8, bits per write-enable lane; `LANES = DATA_W/LANE_W`
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W` registers
- `ZERO_REG`, 1, 1 = register 0 reads 0 and ignores writes
- `BYPASS`, 1, 1 = read ports see the same-cycle write data

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rs_addr`  in  `ADDR_W`  read port A address
- `rt_addr`  in  `ADDR_W`  read port B address
- `rd_addr`  in  `ADDR_W`  write address
- `rd_in`  in  `DATA_W`  write data
- `rd_lane_en`  in  `LANES`  per-lane write enable; bit i covers `rd_in[i*LANE_W +: LANE_W]`
- `rs_out`  out  `DATA_W`  read port A data, combinational
- `rt_out`  out  `DATA_W`  read port B data, combinational
- `scan_step`  in  1  single-cycle pulse; advances the scan pointer
- `scan_addr`  out  `ADDR_W`  current scan pointer, registered
- `scan_out`  out  `DATA_W`  contents of register `scan_addr`, registered

## Operation
- Storage: `DEPTH` x `DATA_W` flops, all cleared by `rst`.
- Write:
  - On each rising edge, for each lane i with `rd_lane_en[i]=1`, lane i of `mem[rd_addr]` takes lane i of `rd_in`.
  - Lanes whose enable is 0 hold their value.
  - `rd_lane_en = 0` means no write.
- Zero register: with `ZERO_REG=1`, writes to address 0 are dropped and every read of address 0 returns 0, on `rs`, `rt` and the scan port. With `ZERO_REG=0`, register 0 is ordinary storage.
- Read:
  - `rs_out = mem[rs_addr]` and `rt_out = mem[rt_addr]`, combinational.
  - Both ports may address the same register.
- Bypass:
  - With `BYPASS=1`, when a read address equals `rd_addr` and any lane is enabled, the read port returns the merged word: `rd_in` lanes where enabled, stored lanes elsewhere.
  - Bypass never applies to address 0 when `ZERO_REG=1`.
  - With `BYPASS=0`, reads always return the stored value, i.e. the pre-edge value.
- Scan:
  - `scan_addr` increments by 1 on each edge where `scan_step=1`, wrapping from `DEPTH-1` to 0.
  - Each edge, `scan_out` loads the post-edge value of the register at the post-edge `scan_addr`. This includes a same-edge write to that register, so the display is never one write stale.
- Reset mid-operation: `rst` immediately (asynchronously) clears all registers, `scan_addr` and `scan_out`. A write coinciding with reset deassertion is honoured only on the first edge with `rst=0`.

## Timing
- Reset values: every `mem` entry 0; `scan_addr = 0`; `scan_out = 0`.
  - `rs_out` and `rt_out` equal 0 during reset, because they follow memory combinationally.
- Write latency: 1 edge into storage.
  - `BYPASS=1`: 0 cycles read-after-write on `rs_out`/`rt_out`.
  - `BYPASS=0`: visible after the edge.
- Scan latency: `scan_addr` and `scan_out` update on the edge that samples `scan_step`. Both are stable for the full following cycle.
- `scan_step` held high steps once per cycle; edge detection is the debouncer's job.
- No handshake and no back-pressure: every input is sampled every cycle.

## Test plan
- Reset then read:
  - assert `rst` mid-run after filling registers 1..31 with `0xA5A5A5A5`, then release;
  - required: `rs_out = rt_out = 0` for all addresses, `scan_addr = 0`, `scan_out = 0`.
- Lane write:
  - write `0x11223344` to r5 with `rd_lane_en = 4'b1111`, then `0xFFFFFFFF` with `rd_lane_en = 4'b0101`;
  - required: reading r5 returns `0x11FF33FF`.
- Zero register:
  - with `ZERO_REG=1`, write `0xDEADBEEF` to r0 with all lanes enabled, reading r0 on rs in the same cycle;
  - required: `rs_out = 0` in the write cycle and afterwards.
  - With `ZERO_REG=0` the same sequence must read back `0xDEADBEEF`.
- Bypass:
  - r7 = `0x00000000`; in one cycle set `rs_addr = rt_addr = rd_addr = 7`, `rd_in = 0x12345678`, `rd_lane_en = 4'b0011`;
  - required: `rs_out = rt_out = 0x00005678` before the edge with `BYPASS=1`, `0x00000000` with `BYPASS=0`.
- Scan wrap:
  - `ADDR_W=2`, r1..r3 = 1,2,3; pulse `scan_step` 5 times;
  - required: `scan_addr` sequence 1,2,3,0,1; `scan_out` sequence 1,2,3,0,1.
- Scan + write collision:
  - `scan_addr = 2`; in one cycle pulse `scan_step` and write `0xCAFE0000` to r3 with all lanes enabled;
  - required: after the edge, `scan_addr = 3` and `scan_out = 0xCAFE0000`.

Source files
------------

// File: rtl/register_mips_param.sv
// MIPS-style register file: two combinational read ports, one byte-lane write port,
// optional hardwired r0, optional write-to-read bypass, and a registered LED scan port.
module register_mips_param #(
   parameter int DATA_W   = 32,
   parameter int LANE_W   = 8,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W-1:0]          rs_addr,
   input  logic [ADDR_W-1:0]          rt_addr,
   input  logic [ADDR_W-1:0]          rd_addr,
   input  logic [DATA_W-1:0]          rd_in,
   input  logic [DATA_W/LANE_W-1:0]   rd_lane_en,
   output logic [DATA_W-1:0]          rs_out,
   output logic [DATA_W-1:0]          rt_out,
   input  logic                       scan_step,
   output logic [ADDR_W-1:0]          scan_addr,
   output logic [DATA_W-1:0]          scan_out
);

   localparam int LANES = DATA_W / LANE_W;
   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_scan_addr;
   logic [DATA_W-1:0] r_scan_out;

   logic              w_wr_en;
   logic [DATA_W-1:0] w_merged;
   logic [ADDR_W-1:0] w_scan_addr_nx;
   logic [DATA_W-1:0] w_scan_out_nx;

   // Writes to a hardwired r0 are squashed here so storage, bypass and scan all agree.
   assign w_wr_en = (|rd_lane_en) && !((ZERO_REG != 0) && (rd_addr == '0));

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      w_merged = r_mem[rd_addr];
      for (int l = 0; l < LANES; l++) begin
         if (rd_lane_en[l]) w_merged[l*LANE_W +: LANE_W] = rd_in[l*LANE_W +: LANE_W];
      end
   end

   always_comb begin
      rs_out = r_mem[rs_addr];
      rt_out = r_mem[rt_addr];
      if ((BYPASS != 0) && w_wr_en && (rs_addr == rd_addr)) rs_out = w_merged;
      if ((BYPASS != 0) && w_wr_en && (rt_addr == rd_addr)) rt_out = w_merged;
      if ((ZERO_REG != 0) && (rs_addr == '0)) rs_out = '0;
      if ((ZERO_REG != 0) && (rt_addr == '0)) rt_out = '0;
   end

   // Scan shows the post-edge contents, so a colliding write is forwarded regardless of BYPASS.
   always_comb begin
      w_scan_addr_nx = r_scan_addr + ADDR_W'(scan_step);
      w_scan_out_nx  = r_mem[w_scan_addr_nx];
      if (w_wr_en && (w_scan_addr_nx == rd_addr)) w_scan_out_nx = w_merged;
      if ((ZERO_REG != 0) && (w_scan_addr_nx == '0)) w_scan_out_nx = '0;
   end

   // NOTE: the register array is cleared by reset because the board relies on a known
   // all-zero state; this forces flops rather than a RAM macro, which is fine at this size.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr_en) begin
         for (int l = 0; l < LANES; l++) begin
            if (rd_lane_en[l]) r_mem[rd_addr][l*LANE_W +: LANE_W] <= rd_in[l*LANE_W +: LANE_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scan_addr <= '0;
         r_scan_out  <= '0;
      end else begin
         r_scan_addr <= w_scan_addr_nx;
         r_scan_out  <= w_scan_out_nx;
      end
   end

   assign scan_addr = r_scan_addr;
   assign scan_out  = r_scan_out;

endmodule

// File: tb/tb_register_mips_param.sv
// Bench for register_mips_param: two 32x32 configurations (r0+bypass, plain) share stimulus
// against an array model; a 4-entry instance exercises scan wrap and scan/write collision.
module tb_register_mips_param;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [4:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
   logic [31:0] rd_in = '0;
   logic [3:0]  rd_lane_en = '0;
   logic        scan_step = 1'b0;
   logic [31:0] a_rs, a_rt, a_scan_out, b_rs, b_rt, b_scan_out;
   logic [4:0]  a_scan_addr, b_scan_addr;

   logic [1:0]  s_rs_addr = '0, s_rt_addr = '0, s_rd_addr = '0;
   logic [31:0] s_rd_in = '0;
   logic [3:0]  s_lane_en = '0;
   logic        s_step = 1'b0;
   logic [31:0] s_rs, s_rt, s_scan_out;
   logic [1:0]  s_scan_addr;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: index 0 = ZERO_REG=1/BYPASS=1 instance, index 1 = ZERO_REG=0/BYPASS=0 instance.
   logic [31:0] mdl [2][32];
   int          sptr [2];

   always #5 clk = ~clk;

   register_mips_param #(.ZERO_REG(1), .BYPASS(1)) dut_a (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .rd_in(rd_in), .rd_lane_en(rd_lane_en), .rs_out(a_rs), .rt_out(a_rt),
      .scan_step(scan_step), .scan_addr(a_scan_addr), .scan_out(a_scan_out));

   register_mips_param #(.ZERO_REG(0), .BYPASS(0)) dut_b (
      .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
      .rd_in(rd_in), .rd_lane_en(rd_lane_en), .rs_out(b_rs), .rt_out(b_rt),
      .scan_step(scan_step), .scan_addr(b_scan_addr), .scan_out(b_scan_out));

   register_mips_param #(.ADDR_W(2)) dut_s (
      .clk(clk), .rst(rst), .rs_addr(s_rs_addr), .rt_addr(s_rt_addr), .rd_addr(s_rd_addr),
      .rd_in(s_rd_in), .rd_lane_en(s_lane_en), .rs_out(s_rs), .rt_out(s_rt),
      .scan_step(s_step), .scan_addr(s_scan_addr), .scan_out(s_scan_out));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input int c, input int a);
      logic [31:0] w;
      if (c == 0 && a == 0) return 32'h0;
      w = mdl[c][a];
      if (c == 0 && a == int'(rd_addr) && rd_lane_en != 4'h0)
         for (int b = 0; b < 4; b++) if (rd_lane_en[b]) w[b*8 +: 8] = rd_in[b*8 +: 8];
      return w;
   endfunction

   function automatic logic [31:0] exp_scan(input int c);
      if (c == 0 && sptr[c] == 0) return 32'h0;
      return mdl[c][sptr[c]];
   endfunction

   task automatic clear_model();
      for (int c = 0; c < 2; c++) begin
         sptr[c] = 0;
         for (int a = 0; a < 32; a++) mdl[c][a] = 32'h0;
      end
   endtask

   task automatic apply(input int rs, input int rt, input int rd, input logic [31:0] din,
                        input logic [3:0] en, input logic step);
      rs_addr = 5'(rs); rt_addr = 5'(rt); rd_addr = 5'(rd);
      rd_in = din; rd_lane_en = en; scan_step = step;
      #2;
   endtask

   task automatic check_comb();
      chk("a_rs", a_rs, exp_read(0, int'(rs_addr)));
      chk("a_rt", a_rt, exp_read(0, int'(rt_addr)));
      chk("b_rs", b_rs, exp_read(1, int'(rs_addr)));
      chk("b_rt", b_rt, exp_read(1, int'(rt_addr)));
   endtask

   // Advance one edge, update the model from the applied stimulus, check the scan port.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
         if (rd_lane_en != 4'h0 && !(c == 0 && rd_addr == 5'd0))
            for (int b = 0; b < 4; b++)
               if (rd_lane_en[b]) mdl[c][int'(rd_addr)][b*8 +: 8] = rd_in[b*8 +: 8];
         sptr[c] = (sptr[c] + int'(scan_step)) % 32;
      end
      chk("a_scan_addr", 32'(a_scan_addr), 32'(sptr[0]));
      chk("a_scan_out", a_scan_out, exp_scan(0));
      chk("b_scan_addr", 32'(b_scan_addr), 32'(sptr[1]));
      chk("b_scan_out", b_scan_out, exp_scan(1));
   endtask

   task automatic step(input int rs, input int rt, input int rd, input logic [31:0] din,
                       input logic [3:0] en, input logic stp);
      apply(rs, rt, rd, din, en, stp);
      check_comb();
      tick();
   endtask

   initial begin
      clear_model();
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // Fill r1..r31, then reset mid-run and confirm everything reads zero.
      for (int a = 1; a < 32; a++) step(a, a - 1, a, 32'hA5A5A5A5, 4'hF, 1'b1);
      apply(0, 0, 0, 32'h0, 4'h0, 1'b0);
      rst = 1'b1;
      #1;
      clear_model();
      for (int a = 0; a < 32; a++) begin
         rs_addr = 5'(a); rt_addr = 5'(31 - a);
         #1;
         chk("rst_a_rs", a_rs, 32'h0);
         chk("rst_a_rt", a_rt, 32'h0);
         chk("rst_b_rs", b_rs, 32'h0);
         chk("rst_b_rt", b_rt, 32'h0);
      end
      chk("rst_a_scan_addr", 32'(a_scan_addr), 32'h0);
      chk("rst_a_scan_out", a_scan_out, 32'h0);
      chk("rst_b_scan_out", b_scan_out, 32'h0);
      chk("rst_s_scan_out", s_scan_out, 32'h0);
      @(posedge clk); #3;
      rst = 1'b0;
      for (int a = 0; a < 32; a++) step(a, 31 - a, 0, 32'h0, 4'h0, 1'b0);

      // Byte-lane write.
      step(5, 5, 5, 32'h11223344, 4'hF, 1'b0);
      step(5, 5, 5, 32'hFFFFFFFF, 4'h5, 1'b0);
      apply(5, 5, 0, 32'h0, 4'h0, 1'b0);
      chk("lane_a_r5", a_rs, 32'h11FF33FF);
      chk("lane_b_r5", b_rt, 32'h11FF33FF);
      tick();

      // Register 0: dropped and reads zero with ZERO_REG=1, ordinary storage otherwise.
      apply(0, 0, 0, 32'hDEADBEEF, 4'hF, 1'b0);
      chk("zero_a_same_cycle", a_rs, 32'h0);
      check_comb();
      tick();
      apply(0, 0, 0, 32'h0, 4'h0, 1'b0);
      chk("zero_a_after", a_rs, 32'h0);
      chk("zero_b_after", b_rs, 32'hDEADBEEF);
      tick();

      // Bypass merge on a partially enabled write to r7 (zero since reset).
      apply(7, 7, 7, 32'h12345678, 4'h3, 1'b0);
      chk("byp_a_rs", a_rs, 32'h00005678);
      chk("byp_a_rt", a_rt, 32'h00005678);
      chk("byp_b_rs", b_rs, 32'h00000000);
      chk("byp_b_rt", b_rt, 32'h00000000);
      tick();

      // Randomised traffic, read addresses biased toward the write address.
      for (int i = 0; i < 400; i++) begin
         int rd = $urandom_range(0, 31);
         int rs = ($urandom_range(0, 2) == 0) ? rd : $urandom_range(0, 31);
         int rt = ($urandom_range(0, 2) == 0) ? rd : $urandom_range(0, 31);
         step(rs, rt, rd, $urandom, 4'($urandom), 1'($urandom));
      end
      apply(0, 0, 0, 32'h0, 4'h0, 1'b0);

      // Small instance: scan wrap, then scan/write collision.
      for (int a = 1; a < 4; a++) begin
         s_rd_addr = 2'(a); s_rd_in = 32'(a); s_lane_en = 4'hF;
         @(posedge clk); #1;
      end
      s_lane_en = 4'h0;
      begin
         int wrap_exp [5] = '{1, 2, 3, 0, 1};
         s_step = 1'b1;
         for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("wrap_scan_addr", 32'(s_scan_addr), 32'(wrap_exp[k]));
            chk("wrap_scan_out", s_scan_out, 32'(wrap_exp[k]));
         end
      end
      @(posedge clk); #1;
      chk("coll_pre_addr", 32'(s_scan_addr), 32'd2);
      s_rd_addr = 2'd3; s_rd_in = 32'hCAFE0000; s_lane_en = 4'hF; s_rs_addr = 2'd3;
      #1;
      chk("coll_bypass_rs", s_rs, 32'hCAFE0000);
      @(posedge clk); #1;
      s_step = 1'b0; s_lane_en = 4'h0;
      chk("coll_scan_addr", 32'(s_scan_addr), 32'd3);
      chk("coll_scan_out", s_scan_out, 32'hCAFE0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
